// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the instruction fetch front-end
package cpu_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with a registered head and flush
// Flush has priority over push and pop; the head holds its last value when the FIFO empties.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_after_pop;

  assign w_pop             = i_pop & (r_count != '0);
  assign w_rd_next         = r_rd_ptr + AW'(w_pop);
  assign w_count_after_pop = r_count - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= r_count + CW'(i_push) - CW'(w_pop);
      // The next head comes from storage if anything remains, else straight from the push.
      if (w_count_after_pop != '0) begin
        r_head <= r_mem[w_rd_next];
      end else if (i_push) begin
        r_head <= i_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && i_push && !i_flush) begin
      assert (r_count != CW'(DEPTH)) else $error("sync_fifo: push while full");
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC owner, IM read issue and instruction queue
// Holds the run FSM, fetch/request PCs, the in-flight flag and redirect kill logic.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        im_rd,
  output logic [13:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;
  logic         r_inflight;

  logic [31:0]  w_redir_pc;
  logic [31:0]  w_issue_pc;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_credit_sum;
  logic         w_credit_ok;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;

  assign w_redir_pc   = redir_pc & ~32'h3;
  assign w_issue_pc   = redir_valid ? w_redir_pc : r_fetch_pc;
  assign w_credit_sum = w_count + CW'(r_inflight);
  // A redirect flushes the queue and kills the returning read, so all credit is free that cycle.
  assign w_credit_ok  = redir_valid | (w_credit_sum < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (fetch_en) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    im_rd = 1'b0;
    if (r_state == S_RUN) begin
      im_rd = fetch_en & w_credit_ok;
    end
  end

  assign im_addr = w_issue_pc[15:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= im_rd;
      if (im_rd) begin
        r_fetch_pc <= w_issue_pc + 32'(INSTR_BYTES);
        r_req_pc   <= w_issue_pc;
      end else if (redir_valid) begin
        r_fetch_pc <= w_redir_pc;
      end
    end
  end

  assign w_push       = r_inflight & ~redir_valid;
  assign w_pop        = out_valid & out_ready & ~redir_valid;
  assign w_push_entry = '{pc: r_req_pc, instr: im_rdata};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (redir_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        im_rd;
  logic [13:0] im_addr;
  logic [31:0] im_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rd;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .im_rd       (im_rd),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {16'hC0DE, 2'b00, pc[15:2]};
  endfunction

  // Instruction SRAM: data for the address read at one edge is valid after it.
  always @(posedge clk) begin
    if (im_rd) im_rdata <= {16'hC0DE, 2'b00, im_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; fetch_en = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    #2;
    check("rst_im_rd", 32'(im_rd), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    tick; tick;
    rst = 1'b1;

    // 1: sequential stream
    fetch_en = 1'b1; out_ready = 1'b1; #1;
    check("t1_idle_rd", 32'(im_rd), 0);
    tick; #1;
    check("t1_first_rd", 32'(im_rd), 1);
    check("t1_addr0", 32'(im_addr), 0);
    check("t1_nvalid0", 32'(out_valid), 0);
    tick; #1;
    check("t1_addr1", 32'(im_addr), 1);
    check("t1_nvalid1", 32'(out_valid), 0);
    tick; #1;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_pc0", out_pc, 0);
    check("t1_instr0", out_instr, word_of(32'h0));
    for (int k = 1; k <= 5; k++) begin
      tick; #1;
      check("t1_pc_seq", out_pc, 32'(4 * k));
      check("t1_addr_seq", 32'(im_addr), 32'(2 + k));
    end

    // 2: stall for 10 cycles, then release
    tick;
    out_ready = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_rd += int'(im_rd);
      if (i == 9) begin
        check("t2_hold_pc", out_pc, 32'd24);
        check("t2_hold_valid", 32'(out_valid), 1);
        check("t2_rd_blocked", 32'(im_rd), 0);
      end
      tick;
    end
    check("t2_reads_in_stall", 32'(n_rd), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t2_resume_pc", out_pc, 32'(24 + 4 * i));
      check("t2_resume_valid", 32'(out_valid), 1);
      tick;
    end

    // 3: redirect with three queued entries and one read in flight
    out_ready = 1'b0;
    tick;
    redir_valid = 1'b1; redir_pc = 32'h100; #1;
    check("t3_head_before", out_pc, 32'd56);
    check("t3_redir_rd", 32'(im_rd), 1);
    check("t3_redir_addr", 32'(im_addr), 32'h40);
    tick;
    redir_valid = 1'b0; out_ready = 1'b1; #1;
    check("t3_flushed", 32'(out_valid), 0);
    tick; #1;
    check("t3_valid", 32'(out_valid), 1);
    check("t3_pc100", out_pc, 32'h100);
    check("t3_instr100", out_instr, word_of(32'h100));
    tick; #1;
    check("t3_pc104", out_pc, 32'h104);

    // 4: redirect together with a pop and a returning read
    tick;
    redir_valid = 1'b1; redir_pc = 32'h200; #1;
    check("t4_head", out_pc, 32'h108);
    check("t4_addr", 32'(im_addr), 32'h80);
    tick;
    redir_valid = 1'b0; #1;
    check("t4_flushed", 32'(out_valid), 0);
    tick; #1;
    check("t4_pc200", out_pc, 32'h200);
    check("t4_valid", 32'(out_valid), 1);
    tick; #1;
    check("t4_pc204", out_pc, 32'h204);

    // 5: asynchronous reset with the queue full
    tick;
    out_ready = 1'b0;
    tick; tick; tick; #1;
    check("t5_full_valid", 32'(out_valid), 1);
    check("t5_full_head", out_pc, 32'h208);
    check("t5_full_no_rd", 32'(im_rd), 0);
    #1;
    rst = 1'b0; #1;
    check("t5_rst_rd", 32'(im_rd), 0);
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_pc", out_pc, 0);
    check("t5_rst_instr", out_instr, 0);
    tick;
    rst = 1'b1; out_ready = 1'b1; fetch_en = 1'b1; #1;
    check("t5_restart_idle", 32'(im_rd), 0);
    tick; #1;
    check("t5_restart_rd", 32'(im_rd), 1);
    check("t5_restart_addr", 32'(im_addr), 0);
    tick; tick; #1;
    check("t5_restart_pc0", out_pc, 0);
    tick; #1;
    check("t5_restart_pc4", out_pc, 32'h4);

    // 6: wrap-around and unaligned redirect
    tick;
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC; #1;
    check("t6_addr_top", 32'(im_addr), 32'h3FFF);
    tick;
    redir_valid = 1'b0; #1;
    check("t6_flushed", 32'(out_valid), 0);
    tick; #1;
    check("t6_pc_top", out_pc, 32'hFFFF_FFFC);
    check("t6_instr_top", out_instr, word_of(32'hFFFF_FFFC));
    tick; #1;
    check("t6_pc_wrap", out_pc, 32'h0);
    check("t6_instr_wrap", out_instr, word_of(32'h0));
    tick;
    redir_valid = 1'b1; redir_pc = 32'h103; #1;
    check("t6_unaligned_addr", 32'(im_addr), 32'h40);
    tick;
    redir_valid = 1'b0; #1;
    check("t6_unaligned_flush", 32'(out_valid), 0);
    tick; #1;
    check("t6_unaligned_pc", out_pc, 32'h100);
    check("t6_unaligned_instr", out_instr, word_of(32'h100));

    // redirect while idle only loads the fetch PC
    rst = 1'b0; #1;
    tick;
    rst = 1'b1; fetch_en = 1'b0; redir_valid = 1'b1; redir_pc = 32'h40; #1;
    check("idle_redir_no_rd", 32'(im_rd), 0);
    tick;
    redir_valid = 1'b0; fetch_en = 1'b1; #1;
    check("idle_still_idle", 32'(im_rd), 0);
    tick; #1;
    check("idle_redir_rd", 32'(im_rd), 1);
    check("idle_redir_addr", 32'(im_addr), 32'h10);
    tick; tick; #1;
    check("idle_redir_pc", out_pc, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
